// File: rtl/decoder_seq_n.sv
// Registered N-to-2^N one-hot decoder with level, single-cycle pulse and
// auto-stepping scan modes; every output is registered.
module decoder_seq_n #(
  parameter int N        = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      sel,
  input  logic              en,
  input  logic              load,
  input  logic [1:0]        mode,
  output logic [2**N-1:0]   out,
  output logic [N-1:0]      idx_q,
  output logic              wrap
);

  localparam int OUTS = 2**N;
  localparam int CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    MODE_LEVEL = 2'b00,
    MODE_PULSE = 2'b01,
    MODE_SCAN  = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  mode_e            mode_q;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     idx_d;
  logic [OUTS-1:0]  out_d;
  logic             wrap_d;
  logic             mode_chg, scan_run, at_term, step;

  function automatic logic [OUTS-1:0] onehot(input logic [N-1:0] i);
    logic [OUTS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  always_comb begin
    mode_chg = (mode != mode_q);
    scan_run = (mode == MODE_SCAN) && en;
    at_term  = (cnt_q == TERM);
    // A mode change restarts the dwell, so it never steps on that edge.
    step     = scan_run && !load && !mode_chg && at_term;

    idx_d = idx_q;
    if (load)
      idx_d = sel;
    else if (step)
      idx_d = idx_q + 1'b1;

    cnt_d = cnt_q;
    if (mode_chg || ((mode == MODE_SCAN) && load))
      cnt_d = '0;
    else if (scan_run)
      cnt_d = at_term ? '0 : cnt_q + 1'b1;

    wrap_d = step && (&idx_q);

    out_d = '0;
    if (mode == MODE_PULSE) begin
      if (load && en)
        out_d = onehot(sel);
    end else if (en) begin
      out_d = onehot(idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_LEVEL;
      cnt_q  <= '0;
      idx_q  <= '0;
      out    <= '0;
      wrap   <= 1'b0;
    end else begin
      mode_q <= mode_e'(mode);
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      out    <= out_d;
      wrap   <= wrap_d;
    end
  end

endmodule

// File: tb/tb_decoder_seq_n.sv
// Directed bench for decoder_seq_n: a N=2/SCAN_DIV=4 instance and a
// N=3/SCAN_DIV=1 instance share clock and reset.
module tb_decoder_seq_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [1:0] sel2 = '0;
  logic       en2 = 1'b0, load2 = 1'b0;
  logic [1:0] mode2 = 2'b00;
  logic [3:0] out2;
  logic [1:0] idx2;
  logic       wrap2;

  logic [2:0] sel3 = '0;
  logic       en3 = 1'b0, load3 = 1'b0;
  logic [1:0] mode3 = 2'b00;
  logic [7:0] out3;
  logic [2:0] idx3;
  logic       wrap3;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  decoder_seq_n #(.N(2), .SCAN_DIV(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .sel(sel2), .en(en2), .load(load2),
    .mode(mode2), .out(out2), .idx_q(idx2), .wrap(wrap2)
  );

  decoder_seq_n #(.N(3), .SCAN_DIV(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .en(en3), .load(load3),
    .mode(mode3), .out(out3), .idx_q(idx3), .wrap(wrap3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk2(input string name, input logic [3:0] eo,
                      input logic [1:0] ei, input logic ew);
    total_cnt++;
    if (out2 !== eo || idx2 !== ei || wrap2 !== ew)
      $display("FAIL %s: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
               name, out2, idx2, wrap2, eo, ei, ew);
    else begin
      pass_cnt++;
      $display("ok   %s: out=%b idx=%0d wrap=%b", name, out2, idx2, wrap2);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    chk2("reset", 4'b0000, 2'd0, 1'b0);
    total_cnt++;
    if (out3 !== 8'h00 || idx3 !== 3'd0 || wrap3 !== 1'b0)
      $display("FAIL reset_n3: got out=%b idx=%0d wrap=%b, expected 0/0/0", out3, idx3, wrap3);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_level();
    mode2 = 2'b00; en2 = 1'b1; load2 = 1'b0;
    tick();
    chk2("level_idx0", 4'b0001, 2'd0, 1'b0);
    load2 = 1'b1; sel2 = 2'd2;
    tick();
    chk2("level_load2", 4'b0100, 2'd2, 1'b0);
    load2 = 1'b0; sel2 = 2'd1;
    tick();
    chk2("level_hold", 4'b0100, 2'd2, 1'b0);
    en2 = 1'b0;
    tick();
    chk2("level_en0", 4'b0000, 2'd2, 1'b0);
    mode2 = 2'b11; en2 = 1'b1;
    tick();
    chk2("reserved_as_level", 4'b0100, 2'd2, 1'b0);
  endtask

  task automatic test_pulse();
    mode2 = 2'b01; en2 = 1'b1; load2 = 1'b1; sel2 = 2'd1;
    tick();
    chk2("pulse_sel1", 4'b0010, 2'd1, 1'b0);
    sel2 = 2'd3;
    tick();
    chk2("pulse_sel3", 4'b1000, 2'd3, 1'b0);
    sel2 = 2'd0;
    tick();
    chk2("pulse_sel0", 4'b0001, 2'd0, 1'b0);
    load2 = 1'b0;
    tick();
    chk2("pulse_end", 4'b0000, 2'd0, 1'b0);
    en2 = 1'b0; load2 = 1'b1; sel2 = 2'd2;
    tick();
    chk2("pulse_load_en0", 4'b0000, 2'd2, 1'b0);
    load2 = 1'b0; en2 = 1'b1;
    tick();
    chk2("pulse_en_only", 4'b0000, 2'd2, 1'b0);
  endtask

  // Cycle k after reset release: index (k-1)/4 mod 4, wrap on each 3->0 step.
  task automatic test_scan();
    logic [1:0] ei;
    logic       ew;
    rst_n = 1'b0;
    mode2 = 2'b10; en2 = 1'b1; load2 = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      ei = 2'((k - 1) / 4);
      ew = (k > 1) && ((k - 1) % 16 == 0);
      chk2($sformatf("scan_k%0d", k), 4'b0001 << ei, ei, ew);
    end
  endtask

  task automatic test_scan_load();
    tick();
    chk2("scan_middwell", 4'b0001, 2'd0, 1'b0);
    load2 = 1'b1; sel2 = 2'd3;
    tick();
    chk2("scan_load3", 4'b1000, 2'd3, 1'b0);
    load2 = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk2($sformatf("scan_dwell3_%0d", k), 4'b1000, 2'd3, 1'b0);
    end
    tick();
    chk2("scan_wrap_after_load", 4'b0001, 2'd0, 1'b1);
    tick();
    chk2("scan_wrap_clear", 4'b0001, 2'd0, 1'b0);
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 5; k++) tick();
    chk2("pre_reset_walk", 4'b0010, 2'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk2("async_reset_now", 4'b0000, 2'd0, 1'b0);
    tick();
    chk2("async_reset_held", 4'b0000, 2'd0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk2($sformatf("restart_%0d", k), 4'b0001, 2'd0, 1'b0);
    end
    tick();
    chk2("restart_step", 4'b0010, 2'd1, 1'b0);
  endtask

  task automatic test_n3_fast_scan();
    logic [2:0] ei;
    logic       ew;
    rst_n = 1'b0;
    mode3 = 2'b10; en3 = 1'b1; load3 = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick();
      ei = 3'((k - 1) % 8);
      ew = (k > 1) && (ei == 3'd0);
      total_cnt++;
      if (out3 !== (8'h01 << ei) || idx3 !== ei || wrap3 !== ew)
        $display("FAIL n3_scan_k%0d: got out=%b idx=%0d wrap=%b, expected out=%b idx=%0d wrap=%b",
                 k, out3, idx3, wrap3, 8'h01 << ei, ei, ew);
      else begin
        pass_cnt++;
        $display("ok   n3_scan_k%0d: out=%b idx=%0d wrap=%b", k, out3, idx3, wrap3);
      end
    end
    mode3 = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      tick();
      total_cnt++;
      if (out3 !== 8'b0000_0100 || idx3 !== 3'd2 || wrap3 !== 1'b0)
        $display("FAIL n3_level_hold_%0d: got out=%b idx=%0d wrap=%b, expected out=00000100 idx=2 wrap=0",
                 k, out3, idx3, wrap3);
      else begin
        pass_cnt++;
        $display("ok   n3_level_hold_%0d: out=%b idx=%0d", k, out3, idx3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_level();
    test_pulse();
    test_scan();
    test_scan_load();
    test_async_reset();
    test_n3_fast_scan();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decoder_seq_n.md
Name: decoder_seq_n

Overview:
Parametrised, registered N-to-2^N one-hot decoder with enable. Successor to the 2-to-4 gate-level enable decoder. Adds three output modes:
- level: held select
- pulse: single-cycle strobe
- scan: auto-stepping walker with programmable dwell

Used for row/strobe selection and for sequencing multiplexed loads (LED/segment scan).

Parameters:
N, 2, select width; output width is 2**N (localparam OUTS, not overridable); legal 1..6
SCAN_DIV, 4, cycles each output stays active in scan mode; legal >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
sel  input  N  select index, captured on load
en  input  1  output enable; 0 forces out to zero (registered)
load  input  1  capture sel into index register this cycle
mode  input  2  00 level, 01 pulse, 10 scan, 11 reserved (behaves as level)
out  output  2**N  registered one-hot decode; bit idx high when active
idx_q  output  N  current index register
wrap  output  1  one-cycle strobe when scan index wraps 2**N-1 -> 0

Behaviour:
- Reset (rst_n=0, async, immediate): out=0, idx_q=0, wrap=0, dwell counter=0, mode register=00. Takes effect mid-operation without waiting for clk.
- Output invariant: out is always all-zero or exactly one-hot; out bit k high implies k==idx_q (as of the previous edge).
- Latency: out reflects idx/en/mode one clock after they are sampled; no combinational path from inputs to out.
- Load: index register <= sel on any edge with load=1, in every mode. Load has priority over scan increment.
- Level (00/11):
  - out <= en ? onehot(next idx) : 0, every cycle.
  - en=0 retains the index.
- Pulse (01):
  - Edge with load=1 and en=1 sets out=onehot(sel) for exactly the following cycle, then 0.
  - Back-to-back loads give back-to-back one-cycle pulses, each decoding its own sel.
  - load with en=0 updates the index only; no pulse.
  - en alone never pulses.
- Scan (10):
  - Dwell counter counts 0..SCAN_DIV-1 while en=1.
  - At terminal count, index <= (index+1) mod 2**N and the counter returns to 0.
  - out <= onehot(index) every cycle while en=1.
  - On the edge where index steps 2**N-1 -> 0, wrap=1 for one cycle; otherwise wrap=0.
  - en=0: counter and index frozen, out=0, wrap=0.
  - load in scan: index <= sel, counter <= 0, no wrap, even at terminal count.
  - SCAN_DIV=1: index advances every cycle.
- Mode change: sampled mode differing from the registered mode clears the dwell counter that cycle. Index is preserved. Pending pulse output is dropped (out follows the new mode's rule next cycle).
- wrap is 0 in all modes except scan.
- Index arithmetic is N bits, natural wrap; no overflow flag.

Test Plan:
1. N=2, level, en=1, load sel=2 at cycle 5 -> out=4'b0100 from cycle 6. Drop en at cycle 10 -> out=0 at cycle 11, idx_q stays 2.
2. N=2, pulse, en=1, load with sel=1,3,0 on consecutive cycles -> out=0010, 1000, 0001 on the next three cycles, then 0000. load with en=0, sel=2 -> idx_q=2, out stays 0.
3. N=2, SCAN_DIV=4, scan, en=1 from reset -> out walks 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001, with wrap=1 exactly once on the 1000->0001 step; repeats every 16 cycles.
4. Scan mid-dwell: load sel=3 -> idx_q=3 next cycle, dwell restarts (out=1000 for 4 full cycles), then wraps with wrap=1.
5. Async reset asserted mid-scan between clock edges -> out=0, idx_q=0, wrap=0 immediately. After release with en=1, scan restarts at 0001.
6. N=3, SCAN_DIV=1, scan -> out walks 8 one-hot codes one per cycle, wrap every 8 cycles. Switch to level mid-walk -> index holds, out holds the current code.
